pipeline_monitor: RTL and testbench

- Receive-side checker for the three-stage add/AND/add datapath (dataIn + c1 -> stage one; stage one & c2 -> stage two; stage two + stage one -> dataOut).
- Taps the datapath's inputs and its dataOut, rebuilds the expected output with shadow registers, and compares every cycle.
- Reports mismatch counts, a sticky error flag and a first-failure capture.
- Sits beside the datapath in the formal/simulation harness and is the consumer end of its output interface.

---
 rtl/pipeline_monitor.sv | 143 ++++++++++++++
 tb/tb_pipeline_monitor.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_monitor.sv
// pipeline_monitor: receive-side checker for the add/AND/add datapath.
// Shadow registers rebuild the expected dataOut from the tapped datapath
// inputs. Once warm-up is over, every enabled cycle is compared against the
// observed output. Counters, a sticky error flag and a first-failure capture
// are kept.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_W0    | first edge after reset; shadows still hold no valid history
//   ST_W1    | sh1 valid, sh2/exp_q not yet
//   ST_W2    | sh1/sh2 valid, exp_q becomes valid on this edge
//   ST_CHECK | exp_q tracks the datapath output; compares allowed
//   ST_HALT  | stopped after a mismatch (STOP_ON_ERR=1); outputs frozen
module pipeline_monitor #(
    parameter int WIDTH       = 32,
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] dut_in,
    input  logic [WIDTH-1:0] dut_c1,
    input  logic [WIDTH-1:0] dut_c2,
    input  logic             dut_rst,
    input  logic [WIDTH-1:0] dut_out,
    input  logic             clr_err,
    output logic             checking,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [WIDTH-1:0] fail_exp,
    output logic [WIDTH-1:0] fail_obs,
    output logic [CNT_W-1:0] fail_idx
);

    typedef enum logic [2:0] {
        ST_W0,
        ST_W1,
        ST_W2,
        ST_CHECK,
        ST_HALT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] sh1;
    logic [WIDTH-1:0] sh2;
    logic [WIDTH-1:0] exp_q;

    logic cmp_fire;
    logic mismatch;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        r = (&v) ? v : v + CNT_W'(1);
        return r;
    endfunction

    // A compare happens only in CHECK while enabled. A clr_err in the same
    // cycle discards the sample.
    assign cmp_fire = (state == ST_CHECK) && en && !clr_err;
    assign mismatch = (dut_out != exp_q);
    assign checking = (state == ST_CHECK);

    // Shadow copy of the datapath. It tracks in every state, so that leaving
    // HALT or re-enabling needs no new warm-up.
    always_ff @(posedge clock) begin
        if (reset) begin
            sh1   <= '0;
            sh2   <= '0;
            exp_q <= '0;
        end else begin
            sh1   <= dut_in + dut_c1;
            sh2   <= sh1 & dut_c2;
            exp_q <= dut_rst ? '0 : (sh2 + sh1);
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_W0;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Warm-up is a fixed three-edge count. clr_err does not
    // shorten it.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_W0:    state_nxt = ST_W1;
            ST_W1:    state_nxt = ST_W2;
            ST_W2:    state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (STOP_ON_ERR && cmp_fire && mismatch) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (clr_err) begin
                    state_nxt = ST_CHECK;
                end
            end
            default:  state_nxt = ST_W0;
        endcase
    end

    // Registered compare result: counters, sticky flag and first-failure capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            err      <= 1'b0;
            err_cnt  <= '0;
            chk_cnt  <= '0;
            fail_exp <= '0;
            fail_obs <= '0;
            fail_idx <= '0;
        end else if (clr_err) begin
            err      <= 1'b0;
            err_cnt  <= '0;
            chk_cnt  <= '0;
            fail_exp <= '0;
            fail_obs <= '0;
            fail_idx <= '0;
        end else if (cmp_fire) begin
            chk_cnt <= sat_inc(chk_cnt);
            if (mismatch) begin
                err     <= 1'b1;
                err_cnt <= sat_inc(err_cnt);
                if (!err) begin
                    fail_exp <= exp_q;
                    fail_obs <= dut_out;
                    fail_idx <= chk_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipeline_monitor.sv
// Directed bench for pipeline_monitor. Three instances share the stimulus:
// the default build, a STOP_ON_ERR=1 build and a CNT_W=4 build. The datapath
// is a small behavioural model whose output can be forced or bit-flipped.
module tb_pipeline_monitor;

    logic        clock = 1'b0;
    logic        reset;
    logic        en;
    logic [31:0] dut_in;
    logic [31:0] dut_c1;
    logic [31:0] dut_c2;
    logic        dut_rst;
    logic        clr_err;
    logic        force_en;
    logic [31:0] force_val;
    logic        flip;
    logic [31:0] p1 = '0;
    logic [31:0] p2 = '0;
    logic [31:0] pout = '0;
    logic [31:0] dut_out;

    logic        m_checking, m_err;
    logic [15:0] m_err_cnt, m_chk_cnt, m_fail_idx;
    logic [31:0] m_fail_exp, m_fail_obs;

    logic        s_checking, s_err;
    logic [15:0] s_err_cnt, s_chk_cnt, s_fail_idx;
    logic [31:0] s_fail_exp, s_fail_obs;

    logic        t_checking, t_err;
    logic [3:0]  t_err_cnt, t_chk_cnt, t_fail_idx;
    logic [31:0] t_fail_exp, t_fail_obs;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    // Datapath model: dataIn + c1, & c2, + stage one.
    always @(posedge clock) begin
        p1   <= dut_in + dut_c1;
        p2   <= p1 & dut_c2;
        pout <= dut_rst ? 32'd0 : (p2 + p1);
    end

    assign dut_out = force_en ? force_val : (pout ^ {31'd0, flip});

    pipeline_monitor u_main (
        .clock(clock), .reset(reset), .en(en), .dut_in(dut_in), .dut_c1(dut_c1),
        .dut_c2(dut_c2), .dut_rst(dut_rst), .dut_out(dut_out), .clr_err(clr_err),
        .checking(m_checking), .err(m_err), .err_cnt(m_err_cnt), .chk_cnt(m_chk_cnt),
        .fail_exp(m_fail_exp), .fail_obs(m_fail_obs), .fail_idx(m_fail_idx)
    );

    pipeline_monitor #(.STOP_ON_ERR(1'b1)) u_stop (
        .clock(clock), .reset(reset), .en(en), .dut_in(dut_in), .dut_c1(dut_c1),
        .dut_c2(dut_c2), .dut_rst(dut_rst), .dut_out(dut_out), .clr_err(clr_err),
        .checking(s_checking), .err(s_err), .err_cnt(s_err_cnt), .chk_cnt(s_chk_cnt),
        .fail_exp(s_fail_exp), .fail_obs(s_fail_obs), .fail_idx(s_fail_idx)
    );

    pipeline_monitor #(.CNT_W(4)) u_sat (
        .clock(clock), .reset(reset), .en(en), .dut_in(dut_in), .dut_c1(dut_c1),
        .dut_c2(dut_c2), .dut_rst(dut_rst), .dut_out(dut_out), .clr_err(clr_err),
        .checking(t_checking), .err(t_err), .err_cnt(t_err_cnt), .chk_cnt(t_chk_cnt),
        .fail_exp(t_fail_exp), .fail_obs(t_fail_obs), .fail_idx(t_fail_idx)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; dut_rst = 1'b0; clr_err = 1'b0; flip = 1'b0;
        dut_in = 32'd5; dut_c1 = 32'd3; dut_c2 = 32'hF;
        force_en = 1'b1; force_val = 32'hDEAD;

        // Warm-up: garbage output is ignored until CHECK.
        cyc();
        check_val("rst_checking", 64'(m_checking), 64'd0);
        check_val("rst_err", 64'(m_err), 64'd0);
        check_val("rst_chk_cnt", 64'(m_chk_cnt), 64'd0);
        check_val("rst_fail_exp", 64'(m_fail_exp), 64'd0);
        reset = 1'b0;
        cyc();
        check_val("wu_checking_e1", 64'(m_checking), 64'd0);
        cyc();
        check_val("wu_checking_e2", 64'(m_checking), 64'd0);
        cyc();
        check_val("wu_checking_e3", 64'(m_checking), 64'd1);
        check_val("wu_chk_cnt_e3", 64'(m_chk_cnt), 64'd0);
        force_val = 32'd16;
        cyc();
        check_val("wu_chk_cnt_1", 64'(m_chk_cnt), 64'd1);
        cyc();
        check_val("wu_chk_cnt_2", 64'(m_chk_cnt), 64'd2);
        check_val("wu_err", 64'(m_err), 64'd0);

        // Steady ramp with a correct datapath.
        reset = 1'b1; force_en = 1'b0; dut_c1 = 32'd1; dut_c2 = 32'hFFFF_FFFF; dut_in = 32'd0;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            dut_in = 32'(i);
            cyc();
        end
        check_val("ramp_err", 64'(m_err), 64'd0);
        check_val("ramp_err_cnt", 64'(m_err_cnt), 64'd0);
        check_val("ramp_chk_cnt", 64'(m_chk_cnt), 64'd97);

        // Single fault on the 10th checked sample (cycle 13, expected 23).
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            dut_in = 32'(j);
            flip = (j == 13 || j == 20);
            cyc();
            if (j == 13) begin
                check_val("flt_err", 64'(m_err), 64'd1);
                check_val("flt_err_cnt", 64'(m_err_cnt), 64'd1);
                check_val("flt_fail_idx", 64'(m_fail_idx), 64'd9);
                check_val("flt_fail_exp", 64'(m_fail_exp), 64'd23);
                check_val("flt_fail_obs", 64'(m_fail_obs), 64'd22);
            end
        end
        flip = 1'b0;
        check_val("flt2_err_cnt", 64'(m_err_cnt), 64'd2);
        check_val("flt2_fail_idx", 64'(m_fail_idx), 64'd9);
        check_val("flt2_fail_exp", 64'(m_fail_exp), 64'd23);
        check_val("flt2_chk_cnt", 64'(m_chk_cnt), 64'd17);

        // dut_rst mid-stream, then a forced zero, then en low for two cycles.
        dut_in = 32'd5; dut_c1 = 32'd3; dut_c2 = 32'hF; force_val = 32'd0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int j = 1; j <= 11; j++) begin
            dut_rst  = (j == 6);
            force_en = (j == 8);
            en       = !(j == 9 || j == 10);
            cyc();
            if (j == 7) begin
                check_val("drst_err", 64'(m_err), 64'd0);
                check_val("drst_chk_cnt", 64'(m_chk_cnt), 64'd4);
            end
            if (j == 8) begin
                check_val("zero_err", 64'(m_err), 64'd1);
                check_val("zero_err_cnt", 64'(m_err_cnt), 64'd1);
                check_val("zero_fail_exp", 64'(m_fail_exp), 64'd16);
                check_val("zero_fail_obs", 64'(m_fail_obs), 64'd0);
                check_val("zero_fail_idx", 64'(m_fail_idx), 64'd4);
            end
            if (j == 10) check_val("en_off_chk_cnt", 64'(m_chk_cnt), 64'd5);
            if (j == 11) check_val("en_on_chk_cnt", 64'(m_chk_cnt), 64'd6);
        end
        dut_rst = 1'b0; force_en = 1'b0; en = 1'b1;

        // STOP_ON_ERR build: halt, freeze, clear, clear-with-fault.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int j = 1; j <= 11; j++) begin
            flip    = (j >= 6 && j <= 8) || (j == 10);
            clr_err = (j == 9 || j == 10);
            cyc();
            if (j == 5) check_val("stop_pre_chk_cnt", 64'(s_chk_cnt), 64'd2);
            if (j == 6) begin
                check_val("stop_checking", 64'(s_checking), 64'd0);
                check_val("stop_err", 64'(s_err), 64'd1);
                check_val("stop_err_cnt", 64'(s_err_cnt), 64'd1);
                check_val("stop_chk_cnt", 64'(s_chk_cnt), 64'd3);
                check_val("stop_fail_idx", 64'(s_fail_idx), 64'd2);
                check_val("stop_fail_obs", 64'(s_fail_obs), 64'd17);
            end
            if (j == 8) begin
                check_val("halt_err_cnt", 64'(s_err_cnt), 64'd1);
                check_val("halt_chk_cnt", 64'(s_chk_cnt), 64'd3);
                check_val("halt_checking", 64'(s_checking), 64'd0);
            end
            if (j == 9) begin
                check_val("clr_checking", 64'(s_checking), 64'd1);
                check_val("clr_err", 64'(s_err), 64'd0);
                check_val("clr_err_cnt", 64'(s_err_cnt), 64'd0);
                check_val("clr_chk_cnt", 64'(s_chk_cnt), 64'd0);
                check_val("clr_fail_obs", 64'(s_fail_obs), 64'd0);
            end
            if (j == 10) begin
                check_val("clrflt_err", 64'(s_err), 64'd0);
                check_val("clrflt_err_cnt", 64'(s_err_cnt), 64'd0);
                check_val("clrflt_chk_cnt", 64'(s_chk_cnt), 64'd0);
            end
            if (j == 11) begin
                check_val("post_clr_chk_cnt", 64'(s_chk_cnt), 64'd1);
                check_val("post_clr_err", 64'(s_err), 64'd0);
            end
        end
        flip = 1'b0; clr_err = 1'b0;

        // Wrap (0xFFFFFFFF + 2 = 1, exp_q = 2) then continuous fault for saturation.
        dut_in = 32'hFFFF_FFFF; dut_c1 = 32'd2; dut_c2 = 32'd3; force_en = 1'b1;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int j = 1; j <= 25; j++) begin
            force_val = (j <= 5) ? 32'd2 : 32'd0;
            cyc();
            if (j == 5) begin
                check_val("wrap_err", 64'(m_err), 64'd0);
                check_val("wrap_chk_cnt", 64'(m_chk_cnt), 64'd2);
            end
        end
        check_val("sat_err_cnt", 64'(t_err_cnt), 64'd15);
        check_val("sat_chk_cnt", 64'(t_chk_cnt), 64'd15);
        check_val("sat_fail_idx", 64'(t_fail_idx), 64'd2);
        check_val("sat_fail_exp", 64'(t_fail_exp), 64'd2);
        check_val("wide_err_cnt", 64'(m_err_cnt), 64'd20);

        // Reset mid-CHECK, then clr_err inside warm-up must not shorten it.
        reset = 1'b1;
        cyc();
        check_val("mid_rst_checking", 64'(m_checking), 64'd0);
        check_val("mid_rst_err", 64'(m_err), 64'd0);
        check_val("mid_rst_err_cnt", 64'(m_err_cnt), 64'd0);
        check_val("mid_rst_chk_cnt", 64'(m_chk_cnt), 64'd0);
        check_val("mid_rst_fail_exp", 64'(m_fail_exp), 64'd0);
        check_val("mid_rst_fail_obs", 64'(m_fail_obs), 64'd0);
        check_val("mid_rst_fail_idx", 64'(m_fail_idx), 64'd0);
        reset = 1'b0;
        cyc();
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        check_val("wu_clr_checking", 64'(m_checking), 64'd0);
        cyc();
        check_val("wu_clr_checking_e3", 64'(m_checking), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
